fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end that replaces the single-register PC plus add-4 loop of the single-cycle core.
- Owns the fetch PC and issues in-order requests to a variable-latency instruction memory.
- Buffers returned instructions in a FIFO and hands them to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with flush and discard of in-flight responses.

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues in-order imem requests under a credit limit and buffers
// tagged instructions for decode. Define FETCH_PERF_CNT_EN to add the perf_* counter ports.
module fetch_unit #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] PC_START   = ADDR_W'(32'h0040_0000)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed,
    output logic [31:0]       perf_stall
`endif
);

    localparam int unsigned       CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned       SUM_W  = CNT_W + 1;
    localparam int unsigned       PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];

    logic              req_fire;
    logic              rsp_fire;
    logic              push;
    logic              pop;
    logic [SUM_W-1:0]  credit_used;
    logic [ADDR_W-1:0] redirect_tgt;

    // Buffered plus in-flight never exceeds the FIFO, so every response has a slot.
    assign credit_used    = SUM_W'(count_q) + SUM_W'(outst_q);
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < SUM_W'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are spurious and ignored.
    assign rsp_fire     = imem_rsp_valid && (outst_q != '0);
    assign push         = rsp_fire && (discard_q == '0) && !redirect_valid;
    assign inst_valid   = (count_q != '0);
    assign pop          = inst_valid && inst_ready;
    assign inst_data    = data_mem_q[rd_ptr_q];
    assign inst_pc      = pc_mem_q[rd_ptr_q];
    assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect_valid) begin
            // Everything still in flight becomes stale; earlier discards merge into the new total.
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            outst_d    = outst_q - CNT_W'(rsp_fire);
            discard_d  = outst_q - CNT_W'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_INC;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_INC;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (rsp_fire && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
            outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= PC_START;
            rsp_pc_q   <= PC_START;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage is cleared on reset so the head outputs read zero until the first push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_q[PTR_W'(i)] <= '0;
                pc_mem_q[PTR_W'(i)]   <= '0;
            end
        end else if (push) begin
            data_mem_q[wr_ptr_q] <= imem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;
    logic [31:0] perf_stall_q;

    // Flushed counts entries thrown away by a redirect plus every stale response dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (pop) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushed_q <= perf_flushed_q + 32'(count_q) - 32'(pop) + 32'(rsp_fire);
            end else if (rsp_fire && (discard_q != '0)) begin
                perf_flushed_q <= perf_flushed_q + 32'd1;
            end
            if (inst_ready && !inst_valid) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: in-order variable-latency memory and a decode-side stream model.
module tb_fetch_unit;

    localparam logic [31:0] PC_START = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    logic [31:0] perf_stall;
`endif

    fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned n_req    = 0;
    int unsigned n_pop    = 0;
    int unsigned mem_lat  = 1;
    bit          rand_lat = 1'b0;
    logic [31:0] exp_pc   = PC_START;
    logic [31:0] mq_addr [$];
    int unsigned mq_due  [$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory presents the oldest request once its latency has elapsed.
    task automatic mem_drive();
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_at(mq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // One clock: observe handshakes, update the models, advance to the next negedge.
    task automatic tick();
        int unsigned lat;
        #1;
        if (inst_valid && inst_ready) begin
            check("pop_pc", inst_pc, exp_pc);
            check("pop_data", inst_data, word_at(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        if (imem_rsp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            lat = rand_lat ? $urandom_range(4, 1) : mem_lat;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
            n_req++;
        end
        if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        mem_drive();
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mq_addr.delete();
        mq_due.delete();
        exp_pc = PC_START;
        #1;
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_fetched", perf_fetched, 32'h0);
        check("rst_perf_flushed", perf_flushed, 32'h0);
        check("rst_perf_stall", perf_stall, 32'h0);
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        mem_drive();
        #1;
    endtask

    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound && !inst_valid; i++) tick();
        check("wait_valid", inst_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned base;
        bit          was_redir;

        // Streaming with a 1-cycle memory
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mem_lat        = 1;
        #1;
        check("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, PC_START);
        tick();
        check("no_bypass", inst_valid, 1'b0);
        tick();
        check("first_valid", inst_valid, 1'b1);
        check("first_pc", inst_pc, PC_START);
        check("first_data", inst_data, word_at(PC_START));
        repeat (6) begin
            tick();
            check("stream_valid", inst_valid, 1'b1);
        end

        // Decode stalled: credit limit caps requests at the buffer depth
        do_reset();
        imem_req_ready = 1'b1;
        mem_lat        = 1;
        base           = n_req;
        repeat (10) tick();
        check("credit_reqs", 32'(n_req - base), 32'd4);
        check("credit_req_valid", imem_req_valid, 1'b0);
        check("credit_inst_valid", inst_valid, 1'b1);
        inst_ready = 1'b1;
        base       = n_pop;
        repeat (12) tick();
        check("drain_count", (n_pop - base) >= 4, 1'b1);

        // Redirect with two 3-cycle requests in flight
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mem_lat        = 3;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_1000;
        #1;
        check("redir_no_req", imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("redir_req_valid", imem_req_valid, 1'b1);
        check("redir_req_addr", imem_req_addr, 32'h0040_1000);
        wait_valid(20);
        check("redir_pc", inst_pc, 32'h0040_1000);
        check("redir_data", inst_data, word_at(32'h0040_1000));

        // Redirect coinciding with a response and a pop; unaligned target
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mem_lat        = 1;
        repeat (4) tick();
        check("pre_rsp_and_valid", imem_rsp_valid && inst_valid, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_2002;
        #1;
        check("coinc_no_req", imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("coinc_empty", inst_valid, 1'b0);
        check("coinc_req_valid", imem_req_valid, 1'b1);
        check("coinc_req_addr", imem_req_addr, 32'h0040_2000);
        repeat (6) tick();

        // Address wrap at the top of memory
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr1", imem_req_addr, 32'h0000_0000);
        repeat (8) tick();

        // Random traffic
        rand_lat = 1'b1;
        base     = n_pop;
        repeat (600) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            inst_ready     = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(24, 0) == 0);
            redirect_pc    = $urandom;
            was_redir      = redirect_valid;
            tick();
            if (was_redir) check("rand_redir_empty", inst_valid, 1'b0);
        end
        check("rand_progress", (n_pop - base) > 40, 1'b1);
        redirect_valid = 1'b0;
        rand_lat       = 1'b0;

        // Reset mid-stream with three entries buffered
        do_reset();
        imem_req_ready = 1'b1;
        mem_lat        = 1;
        repeat (4) tick();
        check("pre_rst_valid", inst_valid, 1'b1);
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        #1;
        check("restart_req_valid", imem_req_valid, 1'b1);
        check("restart_req_addr", imem_req_addr, PC_START);
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
